// File: rtl/my_matrix_multiplier_example_job_sequencer.sv
// Job sequencer: splits one job descriptor into chunks of at most C_CHUNK_BYTES for vadd.
// Optional macro JOB_SEQ_PERF_CNT_EN adds the busy_cycles performance counter output.
module my_matrix_multiplier_example_job_sequencer #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
   parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
   parameter int unsigned C_ADDER_BIT_WIDTH  = 32,
   parameter int unsigned C_CHUNK_BYTES      = 65536
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          s_job_valid,
   output logic                          s_job_ready,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] s_job_addr,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  s_job_size,
   input  logic [C_ADDER_BIT_WIDTH-1:0]  s_job_constant,
   output logic                          ap_start,
   input  logic                          ap_done,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
   output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
   output logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_constant,
   output logic                          busy,
   output logic                          job_done,
   output logic [31:0]                   job_count
`ifdef JOB_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]                   busy_cycles
`endif
);

   localparam int unsigned LP_DW_BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam logic [C_XFER_SIZE_WIDTH-1:0] LpSizeMask =
      ~(C_XFER_SIZE_WIDTH'(LP_DW_BYTES - 1));
   localparam logic [C_XFER_SIZE_WIDTH-1:0] LpChunk = C_XFER_SIZE_WIDTH'(C_CHUNK_BYTES);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

   state_e                        state_q, state_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [C_XFER_SIZE_WIDTH-1:0]  rem_q, rem_d;
   logic [C_ADDER_BIT_WIDTH-1:0]  const_q, const_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_q, ctrl_addr_d;
   logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_size_q, ctrl_size_d;
   logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_const_q, ctrl_const_d;
   logic [31:0]                   count_q, count_d;
   logic                          ready_q, start_q, busy_q, done_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      const_d      = const_q;
      ctrl_addr_d  = ctrl_addr_q;
      ctrl_size_d  = ctrl_size_q;
      ctrl_const_d = ctrl_const_q;
      count_d      = count_q;
      unique case (state_q)
         StIdle: begin
            if (s_job_valid && ready_q) begin
               addr_d  = s_job_addr;
               rem_d   = s_job_size & LpSizeMask;
               const_d = s_job_constant;
               state_d = (rem_d == '0) ? StDone : StStart;
            end
         end
         StStart: state_d = StWait;
         StWait: begin
            if (ap_done) begin
               addr_d  = addr_q + C_M_AXI_ADDR_WIDTH'(ctrl_size_q);
               rem_d   = rem_q - ctrl_size_q;
               state_d = (rem_d == '0) ? StDone : StStart;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // ctrl_* are loaded only when entering START so they hold through WAIT, DONE and IDLE
      if (state_d == StStart) begin
         ctrl_addr_d  = addr_d;
         ctrl_size_d  = (rem_d < LpChunk) ? rem_d : LpChunk;
         ctrl_const_d = const_d;
      end
      if (state_d == StDone) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         rem_q        <= '0;
         const_q      <= '0;
         ctrl_addr_q  <= '0;
         ctrl_size_q  <= '0;
         ctrl_const_q <= '0;
         count_q      <= '0;
         ready_q      <= 1'b0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         const_q      <= const_d;
         ctrl_addr_q  <= ctrl_addr_d;
         ctrl_size_q  <= ctrl_size_d;
         ctrl_const_q <= ctrl_const_d;
         count_q      <= count_d;
         ready_q      <= (state_d == StIdle);
         start_q      <= (state_d == StStart);
         busy_q       <= (state_d != StIdle);
         done_q       <= (state_d == StDone);
      end
   end

`ifdef JOB_SEQ_PERF_CNT_EN
   logic [31:0] busy_cycles_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         busy_cycles_q <= '0;
      end else if (busy_q) begin
         busy_cycles_q <= busy_cycles_q + 32'd1;
      end
   end

   assign busy_cycles = busy_cycles_q;
`endif

   assign s_job_ready             = ready_q;
   assign ap_start                = start_q;
   assign busy                    = busy_q;
   assign job_done                = done_q;
   assign job_count               = count_q;
   assign ctrl_addr_offset        = ctrl_addr_q;
   assign ctrl_xfer_size_in_bytes = ctrl_size_q;
   assign ctrl_constant           = ctrl_const_q;

endmodule

// File: tb/tb_my_matrix_multiplier_example_job_sequencer.sv
// Directed bench for the job sequencer; expected chunks are queued at submit and checked on ap_start.
module tb_my_matrix_multiplier_example_job_sequencer;

   logic        aclk;
   logic        aresetn;
   logic        s_job_valid;
   logic        s_job_ready;
   logic [63:0] s_job_addr;
   logic [31:0] s_job_size;
   logic [31:0] s_job_constant;
   logic        ap_start;
   logic        ap_done;
   logic [63:0] ctrl_addr_offset;
   logic [31:0] ctrl_xfer_size_in_bytes;
   logic [31:0] ctrl_constant;
   logic        busy;
   logic        job_done;
   logic [31:0] job_count;
`ifdef JOB_SEQ_PERF_CNT_EN
   logic [31:0] busy_cycles;
`endif

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] size;
      logic [31:0] c;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   my_matrix_multiplier_example_job_sequencer dut (
      .aclk                    (aclk),
      .aresetn                 (aresetn),
      .s_job_valid             (s_job_valid),
      .s_job_ready             (s_job_ready),
      .s_job_addr              (s_job_addr),
      .s_job_size              (s_job_size),
      .s_job_constant          (s_job_constant),
      .ap_start                (ap_start),
      .ap_done                 (ap_done),
      .ctrl_addr_offset        (ctrl_addr_offset),
      .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
      .ctrl_constant           (ctrl_constant),
      .busy                    (busy),
      .job_done                (job_done),
      .job_count               (job_count)
`ifdef JOB_SEQ_PERF_CNT_EN
      ,
      .busy_cycles             (busy_cycles)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Reference chunking: round down to 64 bytes, split at 65536.
   task automatic push_job(input logic [63:0] addr, input logic [31:0] size,
                           input logic [31:0] c);
      logic [63:0] a;
      logic [31:0] rem;
      logic [31:0] ch;
      a   = addr;
      rem = size & ~32'd63;
      while (rem != 0) begin
         ch = (rem < 32'd65536) ? rem : 32'd65536;
         sb.push_back('{addr: a, size: ch, c: c});
         a   = a + 64'(ch);
         rem = rem - ch;
      end
   endtask

   task automatic submit(input logic [63:0] addr, input logic [31:0] size, input logic [31:0] c);
      push_job(addr, size, c);
      s_job_addr     = addr;
      s_job_size     = size;
      s_job_constant = c;
      s_job_valid    = 1'b1;
      check("accept_ready", s_job_ready, 1'b1);
      tick();
      s_job_valid = 1'b0;
   endtask

   // Entered in the START cycle of a chunk; leaves in the cycle after ap_done.
   task automatic do_chunk(input logic [63:0] ea, input logic [31:0] es, input int waitc,
                           input bit last);
      check("start_pulse", ap_start, 1'b1);
      tick();
      check("wait_no_start", ap_start, 1'b0);
      check("wait_not_ready", s_job_ready, 1'b0);
      repeat (waitc) tick();
      check("wait_addr_hold", ctrl_addr_offset, ea);
      check("wait_size_hold", ctrl_xfer_size_in_bytes, 64'(es));
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      if (last) begin
         check("done_pulse", job_done, 1'b1);
         check("no_start_after_last", ap_start, 1'b0);
         check("ready_low_in_done", s_job_ready, 1'b0);
      end else begin
         check("next_start", ap_start, 1'b1);
         check("no_done_mid_job", job_done, 1'b0);
      end
   endtask

   always @(negedge aclk) begin
      if (aresetn === 1'b1 && ap_start === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_ap_start", ap_start, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("chunk_addr", ctrl_addr_offset, e.addr);
            check("chunk_size", ctrl_xfer_size_in_bytes, 64'(e.size));
            check("chunk_const", ctrl_constant, 64'(e.c));
         end
      end
   end

   initial begin
      aresetn        = 1'b0;
      s_job_valid    = 1'b0;
      s_job_addr     = '0;
      s_job_size     = '0;
      s_job_constant = '0;
      ap_done        = 1'b0;
      repeat (2) tick();
      check("rst_ready", s_job_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_start", ap_start, 1'b0);
      check("rst_done", job_done, 1'b0);
      check("rst_addr", ctrl_addr_offset, 64'h0);
      check("rst_size", ctrl_xfer_size_in_bytes, 64'h0);
      check("rst_const", ctrl_constant, 64'h0);
      check("rst_count", job_count, 64'h0);
`ifdef JOB_SEQ_PERF_CNT_EN
      check("rst_busy_cycles", busy_cycles, 64'h0);
`endif
      aresetn = 1'b1;
      check("ready_before_first_clk", s_job_ready, 1'b0);
      tick();
      check("ready_after_release", s_job_ready, 1'b1);

      // Single chunk
      submit(64'h1000, 32'd4096, 32'd5);
      check("single_busy", busy, 1'b1);
      do_chunk(64'h1000, 32'd4096, 3, 1'b1);
      tick();
      check("single_idle_ready", s_job_ready, 1'b1);
      check("single_done_once", job_done, 1'b0);
      check("single_count", job_count, 64'd1);

      // Multi chunk
      submit(64'h0, 32'd163840, 32'd7);
      do_chunk(64'h0, 32'd65536, 2, 1'b0);
      do_chunk(64'h10000, 32'd65536, 0, 1'b0);
      do_chunk(64'h20000, 32'd32768, 1, 1'b1);
      tick();
      check("multi_count", job_count, 64'd2);

      // Zero and sub-beat sizes
      submit(64'h40, 32'd0, 32'd1);
      check("zero_done", job_done, 1'b1);
      check("zero_no_start", ap_start, 1'b0);
      tick();
      check("zero_ready", s_job_ready, 1'b1);
      submit(64'h80, 32'd63, 32'd1);
      check("r63_done", job_done, 1'b1);
      check("r63_no_start", ap_start, 1'b0);
      tick();
      check("zero_count", job_count, 64'd4);

      // Stray ap_done in IDLE and START
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      check("stray_idle_busy", busy, 1'b0);
      check("stray_idle_start", ap_start, 1'b0);
      check("stray_idle_ready", s_job_ready, 1'b1);
      submit(64'h2000, 32'd128, 32'd9);
      check("stray_start_pulse", ap_start, 1'b1);
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      check("stray_start_no_restart", ap_start, 1'b0);
      check("stray_start_no_done", job_done, 1'b0);
      check("stray_start_busy", busy, 1'b1);
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      check("stray_real_done", job_done, 1'b1);
      tick();
      check("stray_count", job_count, 64'd5);

      // Back-to-back descriptors with valid held high
      push_job(64'h3000, 32'd64, 32'd2);
      push_job(64'h4000, 32'd128, 32'd3);
      s_job_addr     = 64'h3000;
      s_job_size     = 32'd64;
      s_job_constant = 32'd2;
      s_job_valid    = 1'b1;
      tick();
      check("b2b_a_start", ap_start, 1'b1);
      check("b2b_a_ready_start", s_job_ready, 1'b0);
      s_job_addr     = 64'h4000;
      s_job_size     = 32'd128;
      s_job_constant = 32'd3;
      tick();
      check("b2b_a_ready_wait", s_job_ready, 1'b0);
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
      check("b2b_a_done", job_done, 1'b1);
      check("b2b_a_ready_done", s_job_ready, 1'b0);
      tick();
      check("b2b_idle_ready", s_job_ready, 1'b1);
      check("b2b_idle_no_start", ap_start, 1'b0);
      tick();
      s_job_valid = 1'b0;
      do_chunk(64'h4000, 32'd128, 0, 1'b1);
      tick();
      check("b2b_count", job_count, 64'd7);
      check("sb_drained", 64'(sb.size()), 64'd0);

      // Reset during WAIT of chunk 2
      submit(64'h8000, 32'd163840, 32'd4);
      do_chunk(64'h8000, 32'd65536, 1, 1'b0);
      tick();
      #2;
      aresetn = 1'b0;
      #1;
      check("arst_start", ap_start, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", job_done, 1'b0);
      check("arst_ready", s_job_ready, 1'b0);
      check("arst_addr", ctrl_addr_offset, 64'h0);
      check("arst_size", ctrl_xfer_size_in_bytes, 64'h0);
      check("arst_count", job_count, 64'h0);
      sb.delete();
      repeat (2) tick();
      check("arst_no_done", job_done, 1'b0);
      aresetn = 1'b1;
      tick();
      check("rerun_ready", s_job_ready, 1'b1);
      check("rerun_count0", job_count, 64'h0);
`ifdef JOB_SEQ_PERF_CNT_EN
      check("rerun_busy_cycles", busy_cycles, 64'h0);
`endif
      submit(64'h100, 32'd256, 32'd6);
      do_chunk(64'h100, 32'd256, 0, 1'b1);
      tick();
      check("rerun_count1", job_count, 64'd1);
      check("rerun_idle_ready", s_job_ready, 1'b1);
      check("sb_final_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/my_matrix_multiplier_example_job_sequencer.md
# my_matrix_multiplier_example_job_sequencer

Job-level controller in front of the vadd kernel datapath: accepts one job descriptor at a time (base address, total bytes, constant) over a valid/ready handshake and splits the job into chunks of at most C_CHUNK_BYTES. For each chunk it pulses ap_start with the chunk's address and size, then waits for ap_done before issuing the next chunk. It sits between the kernel control/register layer and the vadd datapath. It reports job completion and keeps a job counter.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 64, address width of descriptor and ctrl_addr_offset.
- C_M_AXI_DATA_WIDTH, 512, datapath width; LP_DW_BYTES = C_M_AXI_DATA_WIDTH/8 sets the size granularity.
- C_XFER_SIZE_WIDTH, 32, byte-count width.
- C_ADDER_BIT_WIDTH, 32, constant width.
- C_CHUNK_BYTES, 65536, maximum bytes per ap_start; must be a nonzero multiple of LP_DW_BYTES and < 2^C_XFER_SIZE_WIDTH.

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_job_valid  in  1  descriptor valid.
- s_job_ready  out  1  sequencer can accept a descriptor.
- s_job_addr  in  C_M_AXI_ADDR_WIDTH  job base byte address.
- s_job_size  in  C_XFER_SIZE_WIDTH  job total bytes.
- s_job_constant  in  C_ADDER_BIT_WIDTH  adder constant for the job.
- ap_start  out  1  one-cycle chunk start pulse to vadd.
- ap_done  in  1  one-cycle chunk completion from vadd.
- ctrl_addr_offset  out  C_M_AXI_ADDR_WIDTH  current chunk address.
- ctrl_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  current chunk size.
- ctrl_constant  out  C_ADDER_BIT_WIDTH  latched job constant.
- busy  out  1  high in any state other than IDLE.
- job_done  out  1  one-cycle pulse when a job finishes.
- job_count  out  32  completed jobs, wraps modulo 2^32.

## Operation
- States: IDLE, START, WAIT, DONE. All outputs are registered.
- IDLE: s_job_ready=1. On s_job_valid&&s_job_ready, latch cur_addr=s_job_addr, remaining=s_job_size rounded down to a multiple of LP_DW_BYTES, and const=s_job_constant. If the rounded size is 0 -> DONE, else -> START.
- START: ap_start=1 for exactly this cycle. ctrl_xfer_size_in_bytes=min(remaining, C_CHUNK_BYTES) and ctrl_addr_offset=cur_addr, both valid this cycle -> WAIT.
- WAIT: ctrl_* held stable. On ap_done: cur_addr += chunk, remaining -= chunk. If the new remaining==0 -> DONE, else -> START.
- DONE: job_done=1 for one cycle, job_count++ -> IDLE.
- ap_done outside WAIT is ignored and causes no state change.
- s_job_ready is 0 outside IDLE. Descriptor inputs are sampled only at accept.
- Address arithmetic wraps modulo 2^C_M_AXI_ADDR_WIDTH. Sizes are unsigned with no overflow, because remaining only decreases.

## Timing
- Reset (aresetn=0, asynchronous): state=IDLE. ap_start, job_done, busy=0. s_job_ready=0 while aresetn=0, then 1 from the first clock after deassertion. ctrl_addr_offset, ctrl_xfer_size_in_bytes, ctrl_constant, job_count=0.
- Reset mid-job aborts immediately with no job_done. The vadd datapath must be reset by the same system reset.
- Accept at cycle N -> ap_start high in cycle N+1.
- ap_done at cycle M:
  - If chunks remain, the next ap_start is in M+1.
  - If it was the last chunk, job_done is in M+1 and s_job_ready=1 in M+2.
- Zero-size job: accept at N -> job_done at N+1, ap_start never asserted.
- ctrl_* outputs change only on the cycle START is entered. They hold through WAIT and hold their last values in DONE and IDLE.
- Minimum per-chunk overhead is 2 cycles (START plus a 1-cycle WAIT).

## Configuration
- Macro JOB_SEQ_PERF_CNT_EN.
- Defined: adds output busy_cycles (32 bits, reset 0). It increments on every cycle busy=1, wraps modulo 2^32, and is never cleared except by reset.
- Undefined: no busy_cycles port or logic. All other behaviour is identical.

## Test plan
- Single chunk: addr=0x1000, size=4096, const=5 -> one ap_start with ctrl_addr_offset=0x1000 and size=4096. After ap_done: job_done 1 cycle later, job_count=1.
- Multi-chunk: addr=0x0, size=163840, C_CHUNK_BYTES=65536 -> three ap_starts with (0x0, 65536), (0x10000, 65536), (0x20000, 32768). Each follows the previous ap_done by 1 cycle; job_done after the third ap_done.
- Zero/rounded size: size=0, then size=63 -> job_done one cycle after each accept, no ap_start, job_count +2.
- Stray ap_done: pulse ap_done in IDLE and in START -> no state change, no extra ap_start. The real ap_done in WAIT still completes the chunk.
- Back-to-back jobs: s_job_valid held high with two descriptors -> second accepted in the cycle after the first job's job_done; s_job_ready=0 throughout the first job.
- Reset mid-WAIT: deassert aresetn during WAIT of chunk 2 -> all outputs 0 asynchronously, no job_done. After release, a new job starts cleanly with job_count=0 (busy_cycles=0 if JOB_SEQ_PERF_CNT_EN).
